mul_csv_mac_pipe: RTL and testbench
===================================

Name: mul_csv_mac_pipe

Overview:
- Pipelined, elastic multiply-accumulate unit built on the carry-save multiplier datapath (partial-product generator plus (m,2) compressor slices).
- Computes (XS+XC)*Y from a carry-save multiplier and an unsigned multiplicand.
- Optionally adds the product into a carry-save running accumulator.
- Sits between a carry-save producer (adder tree / previous MAC) and a final carry-propagate adder; result stays in carry-save form.

Parameters:
WidthX, 8, width of xs_i/xc_i (<= WidthY)
WidthY, 8, width of y_i
WidthAcc, WidthX+WidthY+4, accumulator and output width (>= WidthX+WidthY)
Stages, 2, number of register stages (1..4); stage 1 registers compressed product, last stage is accumulator/output register
Speed, 2, compressor structure: 0 linear, otherwise tree

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
in_valid_i  in  1  input transaction valid
in_ready_o  out  1  input accepted when in_valid_i & in_ready_o
xs_i  in  WidthX  multiplier sum vector
xc_i  in  WidthX  multiplier carry vector
y_i  in  WidthY  multiplicand
acc_en_i  in  1  1: add product to current accumulator; 0: load product (restart)
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream ready
ps_o  out  WidthAcc  result sum vector
pc_o  out  WidthAcc  result carry vector

Behaviour:
- Reset (async, rst_ni=0): all stage valid bits 0; ps_o=0, pc_o=0, out_valid_o=0; accumulator cleared to 0. Reset mid-operation flushes every in-flight transaction with no output.
- Datapath: product P = (xs_i+xc_i)*y_i, valid only when xs_i+xc_i < 2^WidthX. Violations are a don't-care in the product, but must never corrupt handshake state.
- Product is zero-extended to WidthAcc.
- Only ps_o+pc_o mod 2^WidthAcc is architecturally defined. Individual PS/PC bit patterns are implementation-dependent; the bench checks only the sum.
- Per-stage valid v[k]; stage k loads when ready[k] = !v[k] | ready[k+1], with ready[Stages] = !out_valid_o | out_ready_i.
- in_ready_o = ready[1], combinational from register state and out_ready_i only; no path from in_valid_i.
- acc_en_i travels with its transaction.
- Latency: Stages cycles from input handshake to out_valid_o with no backpressure. Throughput is 1/cycle under continuous out_ready_i.
- Final stage load:
  - acc_en=1: {ps,pc} <= 4:2 compress of {P_s, P_c, ps_o, pc_o}.
  - acc_en=0: {ps,pc} <= {P_s, P_c}.
  - The accumulator is the output register. Accumulation uses the previous result even if it was just consumed in the same cycle (simultaneous consume + load is legal).
- Output holds stable (ps_o, pc_o, out_valid_o) while out_valid_o & !out_ready_i.
- out_valid_o falls after the handshake if no new transaction loads. ps_o/pc_o retain their value, so a later acc_en=1 transaction still accumulates onto it.
- Overflow: accumulator wraps modulo 2^WidthAcc; no saturation, no flag.
- Stages=1: product compression and accumulation occur in one stage; in_ready_o = ready[Stages].
- Bubbles: a stage with v=0 accepts regardless of downstream; no transaction is dropped or duplicated.

Test Plan:
- Reset then single op: xs=3, xc=4, y=5, acc_en=0, out_ready=1 -> out_valid_o exactly 2 cycles after handshake; ps_o+pc_o=35.
- Accumulate chain: (3,4,5,acc0), then (2,0,10,acc1), then (1,1,1,acc1) back-to-back -> sums 35, 55, 57 on consecutive cycles.
- Max operand: xs=200, xc=55, y=255, acc0 then acc1 -> 65025, then 130050.
- Wrap-around: 17 transactions of (200,55,255) with first acc0, rest acc1 -> final sum 1105425 mod 2^20 = 56849.
- Backpressure: hold out_ready_i=0 for 5 cycles during a 4-transaction stream -> in_ready_o=0 once pipeline full; ps_o/pc_o stable. On release, all 4 results appear in order, none lost or duplicated.
- Async reset mid-stream: assert rst_ni=0 with 2 transactions in flight -> out_valid_o=0 and ps_o=pc_o=0 immediately. Next (1,0,7,acc1) yields sum 7.

Source files
------------

// File: rtl/mul_csv_mac_pipe.sv
// Elastic carry-save multiply-accumulate: (xs+xc)*y reduced to sum/carry form
// and optionally accumulated into a carry-save output register.
module mul_csv_mac_pipe #(
  parameter int WidthX   = 8,
  parameter int WidthY   = 8,
  parameter int WidthAcc = WidthX + WidthY + 4,
  parameter int Stages   = 2,
  parameter int Speed    = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [WidthX-1:0]   xs_i,
  input  logic [WidthX-1:0]   xc_i,
  input  logic [WidthY-1:0]   y_i,
  input  logic                acc_en_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [WidthAcc-1:0] ps_o,
  output logic [WidthAcc-1:0] pc_o
);

  localparam int NR = 2 * WidthX;

  typedef logic [WidthAcc-1:0] word_t;
  typedef struct packed {
    word_t s;
    word_t c;
  } cs_t;

  function automatic cs_t csa(input word_t a, input word_t b, input word_t c);
    cs_t r;
    r.s = a ^ b ^ c;
    r.c = ((a & b) | (a & c) | (b & c)) << 1;
    return r;
  endfunction

  // Reduce all partial-product rows to two vectors: a ripple of 3:2 adders
  // when Speed==0, otherwise a Wallace-style tree of 3:2 levels.
  function automatic cs_t compress(input word_t rows [NR]);
    word_t cur [NR+2];
    word_t nxt [NR+2];
    cs_t   r;
    cs_t   t;
    int    n;
    int    m;
    for (int i = 0; i < NR + 2; i++) begin
      cur[i] = '0;
      nxt[i] = '0;
    end
    for (int i = 0; i < NR; i++) cur[i] = rows[i];
    r.s = cur[0];
    r.c = cur[1];
    if (Speed == 0) begin
      for (int i = 2; i < NR; i++) r = csa(r.s, r.c, cur[i]);
    end else begin
      n = NR;
      for (int lvl = 0; lvl < NR; lvl++) begin
        if (n > 2) begin
          m = 0;
          for (int i = 0; i < NR; i += 3) begin
            if (i + 2 < n) begin
              t          = csa(cur[i], cur[i+1], cur[i+2]);
              nxt[m]     = t.s;
              nxt[m + 1] = t.c;
              m          = m + 2;
            end else begin
              if (i < n) begin
                nxt[m] = cur[i];
                m      = m + 1;
              end
              if (i + 1 < n) begin
                nxt[m] = cur[i+1];
                m      = m + 1;
              end
            end
          end
          cur = nxt;
          n   = m;
        end
      end
      r.s = cur[0];
      r.c = cur[1];
    end
    return r;
  endfunction

  word_t pp [NR];
  cs_t   prod;

  always_comb begin
    for (int i = 0; i < WidthX; i++) begin
      pp[i]          = xs_i[i] ? (word_t'(y_i) << i) : '0;
      pp[WidthX + i] = xc_i[i] ? (word_t'(y_i) << i) : '0;
    end
  end

  assign prod = compress(pp);

  logic [Stages-1:0] v_q;
  logic [Stages-1:0] vin;
  logic [Stages-1:0] rdy;

  // A stage can load if it or any stage downstream of it holds a bubble.
  always_comb begin
    vin[0] = in_valid_i;
    for (int k = 1; k < Stages; k++) vin[k] = v_q[k-1];
    for (int k = 0; k < Stages; k++) begin
      rdy[k] = out_ready_i;
      for (int j = k; j < Stages; j++) rdy[k] = rdy[k] | ~v_q[j];
    end
  end

  assign in_ready_o  = rdy[0];
  assign out_valid_o = v_q[Stages-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q <= '0;
    end else begin
      for (int k = 0; k < Stages; k++) begin
        if (rdy[k]) v_q[k] <= vin[k];
      end
    end
  end

  word_t fin_s;
  word_t fin_c;
  logic  fin_acc;

  if (Stages > 1) begin : g_pipe
    localparam int NP = Stages - 1;
    word_t         s_q [NP];
    word_t         c_q [NP];
    logic [NP-1:0] a_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int k = 0; k < NP; k++) begin
          s_q[k] <= '0;
          c_q[k] <= '0;
        end
        a_q <= '0;
      end else begin
        if (rdy[0] && vin[0]) begin
          s_q[0] <= prod.s;
          c_q[0] <= prod.c;
          a_q[0] <= acc_en_i;
        end
        for (int k = 1; k < NP; k++) begin
          if (rdy[k] && vin[k]) begin
            s_q[k] <= s_q[k-1];
            c_q[k] <= c_q[k-1];
            a_q[k] <= a_q[k-1];
          end
        end
      end
    end

    assign fin_s   = s_q[NP-1];
    assign fin_c   = c_q[NP-1];
    assign fin_acc = a_q[NP-1];
  end else begin : g_direct
    assign fin_s   = prod.s;
    assign fin_c   = prod.c;
    assign fin_acc = acc_en_i;
  end

  word_t ps_q;
  word_t pc_q;
  cs_t   acc_t;
  cs_t   acc_d;

  // ps_q/pc_q are the live accumulator even after the result was consumed.
  always_comb begin
    acc_t   = csa(fin_s, fin_c, ps_q);
    acc_d.s = fin_s;
    acc_d.c = fin_c;
    if (fin_acc) acc_d = csa(acc_t.s, acc_t.c, pc_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ps_q <= '0;
      pc_q <= '0;
    end else if (rdy[Stages-1] && vin[Stages-1]) begin
      ps_q <= acc_d.s;
      pc_q <= acc_d.c;
    end
  end

  assign ps_o = ps_q;
  assign pc_o = pc_q;

endmodule

// File: tb/tb_mul_csv_mac_pipe.sv
// Self-checking bench for mul_csv_mac_pipe: directed vector table, corner
// sequences and randomized traffic against a transaction-level sum model.
module tb_mul_csv_mac_pipe;
  localparam int WX = 8;
  localparam int WY = 8;
  localparam int AW = 20;
  localparam int ST = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          acc_en_i = 1'b0;
  logic          out_ready_i = 1'b0;
  logic [WX-1:0] xs_i = '0;
  logic [WX-1:0] xc_i = '0;
  logic [WY-1:0] y_i = '0;
  logic          in_ready_o;
  logic          out_valid_o;
  logic [AW-1:0] ps_o;
  logic [AW-1:0] pc_o;

  mul_csv_mac_pipe #(
    .WidthX(WX), .WidthY(WY), .WidthAcc(AW), .Stages(ST), .Speed(2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .xs_i(xs_i), .xc_i(xc_i), .y_i(y_i), .acc_en_i(acc_en_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .ps_o(ps_o), .pc_o(pc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0]    xs;
    logic [7:0]    xc;
    logic [7:0]    y;
    logic          acc;
    logic [AW-1:0] exp;
  } vec_t;

  vec_t          tbl [$];
  logic [AW-1:0] expq [$];
  logic [AW-1:0] acc_m = '0;
  logic [AW-1:0] pend_exp = '0;
  logic [AW-1:0] hold_ps = '0;
  logic [AW-1:0] hold_pc = '0;
  int            checks = 0;
  int            errors = 0;
  int            inflight = 0;
  bit            hold_q = 0;
  bit            tbl_mode = 0;
  bit            in_hs = 0;
  bit            last_in_ready = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic logic [AW-1:0] prod(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] y);
    int unsigned p;
    p = (int'(a) + int'(b)) * int'(y);
    return AW'(p);
  endfunction

  // One clock: called at posedge+1 after inputs are driven; samples, scores, advances.
  task automatic cyc();
    logic [AW-1:0] s;
    #1;
    s = ps_o + pc_o;
    last_in_ready = in_ready_o;
    chk("in_ready", in_ready_o, (out_ready_i || inflight < ST));
    if (hold_q) begin
      chk("hold_valid", out_valid_o, 1);
      chk("hold_ps", ps_o, hold_ps);
      chk("hold_pc", pc_o, hold_pc);
    end
    if (out_valid_o && out_ready_i) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out actual=%0d required=none", s);
      end else begin
        chk("sum", s, expq.pop_front());
      end
      inflight--;
    end
    in_hs = in_valid_i && in_ready_o;
    if (in_hs) begin
      acc_m = acc_en_i ? acc_m + prod(xs_i, xc_i, y_i) : prod(xs_i, xc_i, y_i);
      expq.push_back(tbl_mode ? pend_exp : acc_m);
      inflight++;
    end
    hold_q  = out_valid_o && !out_ready_i;
    hold_ps = ps_o;
    hold_pc = pc_o;
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    while (expq.size() > 0 && n < 50) begin
      cyc();
      n++;
    end
    chk("drain_empty", expq.size(), 0);
  endtask

  task automatic drive(input logic [7:0] xs, input logic [7:0] xc, input logic [7:0] y,
                       input logic acc);
    xs_i       = xs;
    xc_i       = xc;
    y_i        = y;
    acc_en_i   = acc;
    in_valid_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n;
    int   c;

    v = '{8'd3, 8'd4, 8'd5, 1'b0, 20'd35};      tbl.push_back(v);
    v = '{8'd2, 8'd0, 8'd10, 1'b1, 20'd55};     tbl.push_back(v);
    v = '{8'd1, 8'd1, 8'd1, 1'b1, 20'd57};      tbl.push_back(v);
    v = '{8'd200, 8'd55, 8'd255, 1'b0, 20'd65025};  tbl.push_back(v);
    v = '{8'd200, 8'd55, 8'd255, 1'b1, 20'd130050}; tbl.push_back(v);
    for (int k = 1; k <= 17; k++) begin
      v.xs  = 8'd200;
      v.xc  = 8'd55;
      v.y   = 8'd255;
      v.acc = (k != 1);
      v.exp = (k == 17) ? 20'd56849 : AW'(k * 65025);
      tbl.push_back(v);
    end

    #12;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_ps", ps_o, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    out_ready_i = 1'b1;
    drive(8'd3, 8'd4, 8'd5, 1'b0);
    cyc();
    in_valid_i = 1'b0;
    chk("lat_after_1", out_valid_o, 0);
    cyc();
    chk("lat_after_2", out_valid_o, 1);
    chk("single_sum", ps_o + pc_o, 35);
    drain();

    tbl_mode = 1;
    out_ready_i = 1'b1;
    foreach (tbl[i]) begin
      pend_exp = tbl[i].exp;
      drive(tbl[i].xs, tbl[i].xc, tbl[i].y, tbl[i].acc);
      cyc();
    end
    tbl_mode = 0;
    drain();

    n = 0;
    c = 0;
    while (n < 4 && c < 40) begin
      out_ready_i = (c >= 5);
      drive(8'(n + 1), 8'(2 * n), 8'(3 + n), (n != 0));
      cyc();
      if (c == 3) chk("bp_full_in_ready", last_in_ready, 0);
      if (in_hs) n++;
      c++;
    end
    chk("bp_accepted", n, 4);
    drain();

    out_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(8'(i + 1), 8'd0, 8'd9, 1'b0);
      cyc();
    end
    in_valid_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midrst_valid", out_valid_o, 0);
    chk("midrst_ps", ps_o, 0);
    chk("midrst_pc", pc_o, 0);
    expq.delete();
    inflight = 0;
    hold_q   = 0;
    acc_m    = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    tbl_mode    = 1;
    pend_exp    = 20'd7;
    out_ready_i = 1'b1;
    drive(8'd1, 8'd0, 8'd7, 1'b1);
    cyc();
    in_valid_i = 1'b0;
    tbl_mode   = 0;
    drain();

    in_valid_i = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!in_valid_i || in_hs) begin
        xs_i       = 8'($urandom_range(0, 255));
        xc_i       = 8'($urandom_range(0, 255 - int'(xs_i)));
        y_i        = 8'($urandom);
        acc_en_i   = 1'($urandom_range(0, 1));
        in_valid_i = ($urandom_range(0, 9) < 7);
      end
      out_ready_i = ($urandom_range(0, 9) < 7);
      cyc();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
